// File: rtl/wb_single_port_ram_if.sv
// Wishbone bus bundle shared by the RAM slave and its master; clock and reset travel with the bus.
// Pure wiring, no latency; flow control is the cyc/stb/ack handshake.
// The slave never stalls; the master holds off until ack.
interface wishbone_if #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int ADDR_SIZE = 6
);
  logic                           clock;
  logic                           reset;
  logic                           cyc;
  logic                           stb;
  logic                           we;
  logic [DATA_SIZE/BYTE_SIZE-1:0] sel;
  logic [ADDR_SIZE-1:0]           addr;
  logic                           tgd;
  logic [DATA_SIZE-1:0]           dat_o_p;
  logic [DATA_SIZE-1:0]           dat_i_p;
  logic                           ack;

  modport slave (
    input  clock, reset, cyc, stb, we, sel, addr, tgd, dat_o_p,
    output dat_i_p, ack
  );

  modport master (
    input  clock, reset, dat_i_p, ack,
    output cyc, stb, we, sel, addr, tgd, dat_o_p
  );
endinterface

// File: rtl/wb_single_port_ram.sv
// Word-organised Wishbone RAM slave; memory starts zeroed.
// Latency: ack exactly BUSY_CYCLES edges after acceptance (minimum 1), one-cycle pulse.
// Backpressure: one access in flight; requests are ignored outside IDLE, and none are dropped once accepted.
module wb_single_port_ram #(
  parameter string RAM_INIT_FILE = "",
  parameter int    BUSY_CYCLES   = 6
) (
  wishbone_if.slave wb_if_s
);
  localparam int DW    = $bits(wb_if_s.dat_o_p);
  localparam int AW    = $bits(wb_if_s.addr);
  localparam int NB    = $bits(wb_if_s.sel);
  localparam int BW    = DW / NB;
  localparam int IW    = AW - 2;
  localparam int WORDS = 2 ** IW;
  localparam int LAT   = (BUSY_CYCLES < 1) ? 1 : BUSY_CYCLES;
  localparam int CW    = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        state;
  logic [CW-1:0] busy_cnt;
  logic [IW-1:0] idx_q;
  logic          req;
  logic [IW-1:0] req_idx;

  logic [DW-1:0] mem [WORDS] = '{default: '0};
  logic unused_init;
  assign unused_init = (RAM_INIT_FILE == "");

  // byte-offset bits and the data tag carry no meaning for a word RAM
  logic unused_bits;
  assign unused_bits = ^{wb_if_s.tgd, wb_if_s.addr[1:0]};

  assign req     = wb_if_s.cyc & wb_if_s.stb;
  assign req_idx = wb_if_s.addr[AW-1:2];

  // Memory is outside the reset domain so an accepted write survives a later abort.
  always_ff @(posedge wb_if_s.clock) begin
    if (!wb_if_s.reset && state == IDLE && req && wb_if_s.we) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_if_s.sel[b]) begin
          mem[req_idx][b*BW +: BW] <= wb_if_s.dat_o_p[b*BW +: BW];
        end
      end
    end
  end

  always_ff @(posedge wb_if_s.clock) begin
    if (wb_if_s.reset) begin
      state           <= IDLE;
      busy_cnt        <= '0;
      idx_q           <= '0;
      wb_if_s.ack     <= 1'b0;
      wb_if_s.dat_i_p <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_if_s.ack <= 1'b0;
          if (req) begin
            idx_q    <= req_idx;
            busy_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (busy_cnt == CW'(LAT - 1)) begin
            wb_if_s.dat_i_p <= mem[idx_q];
            wb_if_s.ack     <= 1'b1;
            busy_cnt        <= '0;
            state           <= ACK;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        ACK: begin
          wb_if_s.ack <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          wb_if_s.ack <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_single_port_ram.sv
// Directed plus randomized bench for wb_single_port_ram against a word-array reference model.
module tb_wb_single_port_ram;
  localparam int LAT = 6;

  wishbone_if wb_if ();

  wb_single_port_ram #(
    .RAM_INIT_FILE(""),
    .BUSY_CYCLES  (LAT)
  ) dut (
    .wb_if_s(wb_if)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [16];

  initial wb_if.clock = 1'b0;
  always #5 wb_if.clock = ~wb_if.clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a) / 4;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    return ref_mem[int'(a) / 4];
  endfunction

  // Called at #1 after a rising edge while the DUT is idle.
  task automatic txn(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic w, input string tag);
    int n;
    wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = w;
    wb_if.sel = s;    wb_if.addr = a;   wb_if.dat_o_p = d;
    @(posedge wb_if.clock);
    if (w) model_write(a, d, s);
    #1;
    // post-acceptance changes must be ignored
    wb_if.cyc = 1'b0; wb_if.stb = 1'b0; wb_if.we = 1'b1;
    wb_if.sel = 4'hF; wb_if.addr = 6'($urandom); wb_if.dat_o_p = $urandom;
    n = 0;
    while (n < 30 && wb_if.ack !== 1'b1) begin
      @(posedge wb_if.clock); #1;
      n++;
    end
    check($sformatf("%s_latency", tag), n, LAT);
    check($sformatf("%s_data", tag), wb_if.dat_i_p, model_read(a));
    wb_if.we = 1'b0;
    @(posedge wb_if.clock); #1;
    check($sformatf("%s_ack_pulse", tag), {31'b0, wb_if.ack}, 32'h0);
  endtask

  initial begin
    int acks;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    wb_if.reset = 1'b1; wb_if.cyc = 1'b0; wb_if.stb = 1'b0; wb_if.we = 1'b0;
    wb_if.sel = '0; wb_if.addr = '0; wb_if.tgd = 1'b0; wb_if.dat_o_p = '0;

    repeat (2) @(posedge wb_if.clock);
    #1;
    wb_if.reset = 1'b0;
    check("reset_ack", {31'b0, wb_if.ack}, 32'h0);
    check("reset_dat", wb_if.dat_i_p, 32'h0);

    // fresh memory reads as zero
    txn(6'h04, 32'h0, 4'h0, 1'b0, "zero_read");

    txn(6'h08, 32'hDEADBEEF, 4'hF, 1'b1, "first_write");
    check("first_write_const", wb_if.dat_i_p, 32'hDEADBEEF);

    for (int i = 0; i <= 38; i++) begin
      txn(6'(4 * i), $urandom, 4'hF, 1'b1, $sformatf("seq_%0d", i));
    end

    txn(6'd14, 32'h0, 4'hF, 1'b1, "misaligned_wr");
    check("misaligned_const", wb_if.dat_i_p, 32'h0);
    txn(6'd12, $urandom, 4'hF, 1'b0, "aligned_rd");
    check("aligned_rd_const", wb_if.dat_i_p, 32'h0);

    txn(6'd0, 32'h11223344, 4'hF, 1'b1, "partial_base");
    txn(6'd0, 32'hAABBCCDD, 4'b0101, 1'b1, "partial_wr");
    check("partial_const", wb_if.dat_i_p, 32'h11BB33DD);

    txn(6'd0, 32'hFFFFFFFF, 4'h0, 1'b1, "sel_zero");
    check("sel_zero_const", wb_if.dat_i_p, 32'h11BB33DD);

    // abort: reset two edges after acceptance, the accepted write persists
    wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = 1'b1;
    wb_if.sel = 4'hF; wb_if.addr = 6'd20; wb_if.dat_o_p = 32'hCAFEF00D;
    @(posedge wb_if.clock);
    model_write(6'd20, 32'hCAFEF00D, 4'hF);
    #1;
    wb_if.cyc = 1'b0; wb_if.stb = 1'b0; wb_if.we = 1'b0;
    repeat (2) @(posedge wb_if.clock);
    #1;
    wb_if.reset = 1'b1;
    @(posedge wb_if.clock);
    #1;
    wb_if.reset = 1'b0;
    check("abort_dat_cleared", wb_if.dat_i_p, 32'h0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_if.ack === 1'b1) acks++;
      @(posedge wb_if.clock); #1;
    end
    check("abort_no_ack", acks, 0);
    txn(6'd20, 32'h0, 4'h0, 1'b0, "after_abort");
    check("after_abort_const", wb_if.dat_i_p, 32'hCAFEF00D);

    for (int i = 0; i < 40; i++) begin
      txn(6'($urandom), $urandom, 4'($urandom), 1'($urandom), $sformatf("rand_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
